// File: rtl/rr_packet_arbiter.sv
// Packet-aware round-robin arbiter for one router output port.
// A grant is held from selection until end-of-frame or a timeout.
module rr_packet_arbiter #(
  parameter int N           = 16,
  parameter int START_TMO   = 8,
  parameter int MAX_PKT_CYC = 64
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [N-1:0]         request,
  input  logic [N-1:0]         frame_n,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 busy,
  output logic                 tmo_err
);

  localparam int IW   = $clog2(N);
  localparam int CMAX = (START_TMO > MAX_PKT_CYC) ?
                        START_TMO : MAX_PKT_CYC;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [CW-1:0] SOF_LAST = CW'(START_TMO - 1);
  localparam logic [CW-1:0] PKT_LAST = CW'(MAX_PKT_CYC - 1);
  localparam logic [IW-1:0] ID_LAST  = IW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_SOF,
    S_BUSY
  } state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [IW-1:0] id_q, id_d;
  logic          busy_q, busy_d;
  logic          tmo_q, tmo_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [IW-1:0] win;
  logic [IW-1:0] ptr_nxt;
  logic          rel;

  // First requester at or after base, wrapping past N-1.
  function automatic logic [IW-1:0] rr_pick(
    input logic [N-1:0]  req,
    input logic [IW-1:0] base
  );
    logic [IW-1:0] res;
    logic [IW-1:0] sel;
    logic          hit;
    int            idx;
    res = base;
    hit = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx = int'(base) + i;
      if (idx >= N) idx = idx - N;
      sel = IW'(idx);
      if (!hit && req[sel]) begin
        hit = 1'b1;
        res = sel;
      end
    end
    return res;
  endfunction

  assign win     = rr_pick(request, ptr_q);
  assign ptr_nxt = (id_q == ID_LAST) ? '0 : id_q + IW'(1);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    id_d    = id_q;
    busy_d  = busy_q;
    tmo_d   = 1'b0;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    rel     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (|request) begin
          grant_d      = '0;
          grant_d[win] = 1'b1;
          id_d         = win;
          busy_d       = 1'b1;
          cnt_d        = '0;
          state_d      = S_WAIT_SOF;
        end
      end
      S_WAIT_SOF: begin
        if (!frame_n[id_q]) begin
          state_d = S_BUSY;
          cnt_d   = '0;
        end else if (!request[id_q]) begin
          rel = 1'b1;
        end else if (cnt_q == SOF_LAST) begin
          rel   = 1'b1;
          tmo_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_BUSY: begin
        if (frame_n[id_q]) begin
          rel = 1'b1;
        end else if (cnt_q == PKT_LAST) begin
          rel   = 1'b1;
          tmo_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
        id_d    = '0;
        busy_d  = 1'b0;
      end
    endcase

    // Release also rotates priority past the port just served.
    if (rel) begin
      grant_d = '0;
      id_d    = '0;
      busy_d  = 1'b0;
      ptr_d   = ptr_nxt;
      cnt_d   = '0;
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      id_q    <= '0;
      busy_q  <= 1'b0;
      tmo_q   <= 1'b0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      id_q    <= id_d;
      busy_q  <= busy_d;
      tmo_q   <= tmo_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grant    = grant_q;
  assign grant_id = id_q;
  assign busy     = busy_q;
  assign tmo_err  = tmo_q;

endmodule

// File: tb/tb_rr_packet_arbiter.sv
// Bench for rr_packet_arbiter: directed scenarios plus random traffic,
// checked every cycle against a transaction-level model.
module tb_rr_packet_arbiter;

  localparam int N           = 16;
  localparam int START_TMO   = 8;
  localparam int MAX_PKT_CYC = 64;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic [N-1:0]  request = '0;
  logic [N-1:0]  frame_n = '1;
  logic [N-1:0]  grant;
  logic [3:0]    grant_id;
  logic          busy;
  logic          tmo_err;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  rr_packet_arbiter #(
    .N(N),
    .START_TMO(START_TMO),
    .MAX_PKT_CYC(MAX_PKT_CYC)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .request(request),
    .frame_n(frame_n),
    .grant(grant),
    .grant_id(grant_id),
    .busy(busy),
    .tmo_err(tmo_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // Model: who owns the port, whether its packet started,
  // how many cycles the current phase has lasted.
  typedef struct {
    int owner;
    bit sof;
    int age;
    int ptr;
    bit tmo;
  } m_t;

  m_t m;

  function automatic m_t m_step(m_t s,
                                logic [N-1:0] req,
                                logic [N-1:0] fr);
    m_t n = s;
    bit rel = 1'b0;
    n.tmo = 1'b0;
    if (s.owner < 0) begin
      for (int off = 0; off < N; off++) begin
        int p = (s.ptr + off) % N;
        if (n.owner < 0 && req[p]) begin
          n.owner = p;
          n.sof   = 1'b0;
          n.age   = 0;
        end
      end
    end else begin
      n.age = s.age + 1;
      if (!s.sof) begin
        if (!fr[s.owner]) begin
          n.sof = 1'b1;
          n.age = 0;
        end else if (!req[s.owner]) begin
          rel = 1'b1;
        end else if (n.age == START_TMO) begin
          rel   = 1'b1;
          n.tmo = 1'b1;
        end
      end else begin
        if (fr[s.owner]) begin
          rel = 1'b1;
        end else if (n.age == MAX_PKT_CYC) begin
          rel   = 1'b1;
          n.tmo = 1'b1;
        end
      end
      if (rel) begin
        n.ptr   = (s.owner + 1) % N;
        n.owner = -1;
      end
    end
    return n;
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      m <= '{owner: -1, sof: 1'b0, age: 0, ptr: 0, tmo: 1'b0};
    else
      m <= m_step(m, request, frame_n);
  end

  always @(negedge clock) begin
    if (chk_en) begin
      chk("grant", 32'(grant),
          (m.owner >= 0) ? (32'd1 << m.owner) : 32'd0);
      chk("grant_id", 32'(grant_id),
          (m.owner >= 0) ? 32'(m.owner) : 32'd0);
      chk("busy", 32'(busy), 32'(m.owner >= 0));
      chk("tmo_err", 32'(tmo_err), 32'(m.tmo));
      chk("busy_or", 32'(busy), 32'(|grant));
      chk("onehot", 32'($onehot0(grant)), 32'd1);
    end
  end

  int n;
  logic [N-1:0] in_pkt;
  logic [N-1:0] rq;

  initial begin
    // Reset state
    repeat (3) @(negedge clock);
    chk_en = 1'b1;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_id", 32'(grant_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tmo", 32'(tmo_err), 32'd0);
    reset_n = 1'b1;
    @(negedge clock);

    // 1: basic packet then next port
    request = 16'hfff0;
    @(negedge clock);
    chk("t1_grant", 32'(grant), 32'h0010);
    chk("t1_id", 32'(grant_id), 32'd4);
    frame_n = ~16'h0010;
    repeat (5) @(negedge clock);
    frame_n = '1;
    @(negedge clock);
    chk("t1_rel", 32'(grant), 32'd0);
    @(negedge clock);
    chk("t1_next", 32'(grant), 32'h0020);
    request = '0;
    @(negedge clock);

    // 2: wrap from ptr=15
    request = 16'h4000;
    @(negedge clock);
    chk("t2_g14", 32'(grant), 32'h4000);
    request = '0;
    @(negedge clock);
    request = 16'h4001;
    @(negedge clock);
    chk("t2_wrap", 32'(grant), 32'h0001);
    chk("t2_id", 32'(grant_id), 32'd0);
    request = '0;
    @(negedge clock);

    // 3: start-of-frame timeout
    request = 16'h0100;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (grant == 16'h0100) n++;
      else break;
    end
    chk("t3_len", 32'(n), 32'd8);
    chk("t3_tmo", 32'(tmo_err), 32'd1);
    request = 16'h0301;
    @(negedge clock);
    chk("t3_ptr9", 32'(grant), 32'h0200);
    chk("t3_tmo_lo", 32'(tmo_err), 32'd0);
    request = '0;
    @(negedge clock);

    // 4a: packet too long
    request = 16'h0010;
    frame_n = ~16'h0010;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (grant == 16'h0010) n++;
      else break;
    end
    request = '0;
    frame_n = '1;
    chk("t4a_len", 32'(n), 32'd65);
    chk("t4a_tmo", 32'(tmo_err), 32'd1);
    @(negedge clock);

    // 4b: end of frame on the limit cycle
    request = 16'h0010;
    frame_n = ~16'h0010;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (grant == 16'h0010) begin
        n++;
        if (n == 65) begin
          frame_n = '1;
          request = '0;
        end
      end else break;
    end
    chk("t4b_len", 32'(n), 32'd65);
    chk("t4b_tmo", 32'(tmo_err), 32'd0);
    @(negedge clock);

    // 5: request withdrawn while waiting for SOF
    request = 16'h0008;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (grant == 16'h0008) begin
        n++;
        if (n == 3) request = '0;
      end else break;
    end
    chk("t5_len", 32'(n), 32'd3);
    chk("t5_tmo", 32'(tmo_err), 32'd0);
    request = 16'h0018;
    @(negedge clock);
    chk("t5_ptr4", 32'(grant), 32'h0010);
    request = '0;
    @(negedge clock);

    // 6: asynchronous reset mid-packet
    request = 16'h0010;
    frame_n = ~16'h0010;
    repeat (4) @(negedge clock);
    chk("t6_busy", 32'(busy), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_grant", 32'(grant), 32'd0);
    chk("t6_id", 32'(grant_id), 32'd0);
    chk("t6_busy0", 32'(busy), 32'd0);
    chk("t6_tmo", 32'(tmo_err), 32'd0);
    request = 16'hff01;
    frame_n = '1;
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk("t6_ptr0", 32'(grant), 32'h0001);
    chk("t6_id0", 32'(grant_id), 32'd0);
    request = '0;
    @(negedge clock);

    // Random traffic
    in_pkt = '0;
    rq = '0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clock);
      for (int p = 0; p < N; p++) begin
        if (in_pkt[p]) begin
          if ($urandom_range(0, (cyc % 1000 < 500) ? 12 : 120) == 0)
            in_pkt[p] = 1'b0;
        end else if ($urandom_range(0, 5) == 0) begin
          in_pkt[p] = 1'b1;
        end
        if ($urandom_range(0, 7) == 0) rq[p] = ~rq[p];
      end
      request = rq;
      frame_n = ~in_pkt;
      if (cyc % 1500 == 777) begin
        #2 reset_n = 1'b0;
        #2 reset_n = 1'b1;
      end
    end

    @(negedge clock);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
